// File: rtl/rvfi_pkg.sv
// RVFI record type plus the trace-side halt and exit-code definitions.
package rvfi_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
    } rvfi_instr_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } trace_halt_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ECALL   = 2'd1,
        TIMEOUT = 2'd2
    } trace_exit_e;

    localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// Multi-push, single-pop FIFO. Up to NR_PUSH entries are written per cycle
// into consecutive slots starting at the write pointer; the caller guarantees
// push_cnt_i never exceeds the free space.
module rvfi_trace_fifo #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NR_PUSH = 2,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned PTR_W  = AW + 1,
    localparam int unsigned CNT_W  = $clog2(NR_PUSH + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [CNT_W-1:0]                 push_cnt_i,
    input  logic [NR_PUSH-1:0][DATA_W-1:0]   push_data_i,
    input  logic                             pop_i,
    output logic [DATA_W-1:0]                head_o,
    output logic                             empty_o,
    output logic [PTR_W-1:0]                 count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic              do_pop;

    // The extra pointer bit keeps full (count == DEPTH) distinct from empty.
    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer bookkeeping; reset discards every stored entry at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_q + PTR_W'(push_cnt_i);
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

    // Storage array; contents are meaningless until covered by the pointers.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(NR_PUSH); k++) begin
            if (k < int'(push_cnt_i)) begin
                mem_q[wptr_q[AW-1:0] + AW'(k)] <= push_data_i[k];
            end
        end
    end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Collects retired/trapping RVFI commit records, buffers them in program order
// and hands them one at a time to a trace sink. Also sequences end of
// simulation: ecall or timeout -> drain the buffer -> done with exit code.
module rvfi_commit_serializer
    import rvfi_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000,
    localparam int unsigned PORT_W = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output logic                              trace_valid_o,
    input  logic                              trace_ready_i,
    output rvfi_instr_t                       trace_o,
    output logic [PORT_W-1:0]                 trace_port_o,
    output logic                              overflow_o,
    output logic                              sim_done_o,
    output logic [1:0]                        exit_code_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(NR_COMMIT_PORTS + 1);
    localparam int unsigned REC_W = $bits(rvfi_instr_t);
    localparam int unsigned ENT_W = REC_W + PORT_W;

    trace_halt_e                            state_q, state_d;
    trace_exit_e                            exit_q, exit_d;
    logic [31:0]                            cycle_q;
    logic                                   overflow_q;
    logic [NR_COMMIT_PORTS-1:0]             keep;
    logic                                   ecall_hit;
    logic                                   drop_hit;
    logic                                   timeout_hit;
    logic [CNT_W-1:0]                       push_cnt;
    logic [NR_COMMIT_PORTS-1:0][ENT_W-1:0]  push_data;
    logic [ENT_W-1:0]                       head;
    logic                                   fifo_empty;
    logic [PTR_W-1:0]                       fifo_cnt;
    logic                                   pop;

    // Pick the qualifying ports that get a slot: free space is measured before
    // this cycle's pop, and an ecall cuts off every younger port silently.
    always_comb begin
        int   slot;
        int   free;
        logic cut;
        keep      = '0;
        ecall_hit = 1'b0;
        drop_hit  = 1'b0;
        slot      = 0;
        cut       = 1'b0;
        free      = int'(DEPTH) - int'(fifo_cnt);
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (state_q == RUN && (rvfi_i[i].valid || rvfi_i[i].trap) && !cut) begin
                if (slot < free) begin
                    keep[i] = 1'b1;
                    slot++;
                    if (rvfi_i[i].valid && rvfi_i[i].insn == ECALL_INSN) begin
                        ecall_hit = 1'b1;
                        cut       = 1'b1;
                    end
                end else begin
                    drop_hit = 1'b1;
                end
            end
        end
        push_cnt = CNT_W'(slot);
    end

    // Compact the kept records into consecutive write slots, oldest port first.
    always_comb begin
        int slot;
        push_data = '0;
        slot      = 0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (keep[i]) begin
                for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
                    if (k == slot) begin
                        push_data[k] = {PORT_W'(i), rvfi_i[i]};
                    end
                end
                slot++;
            end
        end
    end

    rvfi_trace_fifo #(
        .DATA_W  (ENT_W),
        .NR_PUSH (NR_COMMIT_PORTS),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign timeout_hit   = (cycle_q >= TIMEOUT_CYCLES);
    assign trace_valid_o = !fifo_empty;
    assign pop           = trace_valid_o && trace_ready_i;
    assign trace_o       = fifo_empty ? '0 : rvfi_instr_t'(head[REC_W-1:0]);
    assign trace_port_o  = fifo_empty ? '0 : head[ENT_W-1:REC_W];
    assign overflow_o    = overflow_q;
    assign sim_done_o    = (state_q == DONE);
    assign exit_code_o   = exit_q;

    // Halt sequencing: ecall beats timeout; DONE follows the pop that empties
    // the buffer (or the first DRAIN cycle if it was already empty).
    always_comb begin
        state_d = state_q;
        exit_d  = exit_q;
        unique case (state_q)
            RUN: begin
                if (ecall_hit) begin
                    state_d = DRAIN;
                    exit_d  = ECALL;
                end else if (timeout_hit) begin
                    state_d = DRAIN;
                    exit_d  = TIMEOUT;
                end
            end
            DRAIN: begin
                if (fifo_empty || (fifo_cnt == PTR_W'(1) && pop)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // Halt state, exit code, saturating cycle counter and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            exit_q     <= NONE;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exit_q  <= exit_d;
            if (cycle_q != '1) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (drop_hit) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer: directed scenarios plus random episodes,
// all checked cycle by cycle against a queue-based reference model.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 8;
    localparam int TMO   = 20;
    localparam int PW    = 1;

    logic                  clk_i  = 1'b0;
    logic                  rst_ni = 1'b0;
    rvfi_instr_t [NR-1:0]  rvfi;
    logic                  ready;
    logic                  tv;
    rvfi_instr_t           tr;
    logic [PW-1:0]         tp;
    logic                  ovf;
    logic                  done;
    logic [1:0]            ec;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        rvfi_instr_t rec;
        int          port;
    } ent_t;

    ent_t mq[$];
    int   m_cnt;
    bit   m_halting;
    bit   m_done;
    bit   m_ovf;
    int   m_exit;

    always #5 clk_i = ~clk_i;

    rvfi_commit_serializer #(
        .NR_COMMIT_PORTS (NR),
        .DEPTH           (DEPTH),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rvfi_i        (rvfi),
        .trace_valid_o (tv),
        .trace_ready_i (ready),
        .trace_o       (tr),
        .trace_port_o  (tp),
        .overflow_o    (ovf),
        .sim_done_o    (done),
        .exit_code_o   (ec)
    );

    function automatic rvfi_instr_t rand_rec(bit v, bit t, bit is_ecall);
        rvfi_instr_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = t;
        r.order    = {$urandom, $urandom};
        r.insn     = $urandom;
        if (r.insn == 32'h0000_0073) r.insn = 32'h0000_0013;
        if (is_ecall) r.insn = 32'h0000_0073;
        r.halt     = 1'($urandom);
        r.intr     = 1'($urandom);
        r.mode     = 2'($urandom);
        r.rd_addr  = 5'($urandom);
        r.rd_wdata = $urandom;
        r.pc_rdata = $urandom;
        r.pc_wdata = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cnt     = 0;
        m_halting = 0;
        m_done    = 0;
        m_ovf     = 0;
        m_exit    = 0;
    endtask

    // One clock of behaviour from the rules: qualify, fit into free space,
    // stop at ecall, pop the head, then advance the halt sequence.
    task automatic model_step();
        ent_t acc[$];
        ent_t e;
        int   free;
        bit   ecall;
        bit   do_pop;
        do_pop = (mq.size() != 0) && ready;
        free   = DEPTH - mq.size();
        ecall  = 0;
        if (!m_halting) begin
            for (int i = 0; i < NR; i++) begin
                if (ecall) break;
                if (rvfi[i].valid || rvfi[i].trap) begin
                    if (acc.size() < free) begin
                        e.rec  = rvfi[i];
                        e.port = i;
                        acc.push_back(e);
                        if (rvfi[i].valid && rvfi[i].insn == 32'h0000_0073) ecall = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
        foreach (acc[j]) mq.push_back(acc[j]);
        if (m_halting && !m_done && mq.size() == 0) m_done = 1;
        if (!m_halting) begin
            if (ecall) begin
                m_halting = 1;
                m_exit    = 1;
            end else if (m_cnt >= TMO) begin
                m_halting = 1;
                m_exit    = 2;
            end
        end
        m_cnt++;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (mq.size() != 0);
        checks++;
        assert (tv === ev) else begin
            failures++;
            $error("FAIL trace_valid observed=%0b expected=%0b", tv, ev);
        end
        if (ev) begin
            checks++;
            assert (tr === mq[0].rec) else begin
                failures++;
                $error("FAIL trace_rec observed=%h expected=%h", tr, mq[0].rec);
            end
            checks++;
            assert (tp === PW'(mq[0].port)) else begin
                failures++;
                $error("FAIL trace_port observed=%0d expected=%0d", tp, mq[0].port);
            end
        end
        checks++;
        assert (ovf === m_ovf) else begin
            failures++;
            $error("FAIL overflow observed=%0b expected=%0b", ovf, m_ovf);
        end
        checks++;
        assert (done === m_done) else begin
            failures++;
            $error("FAIL sim_done observed=%0b expected=%0b", done, m_done);
        end
        checks++;
        assert (ec === 2'(m_exit)) else begin
            failures++;
            $error("FAIL exit_code observed=%0d expected=%0d", ec, m_exit);
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check, advance the model, then move to just after the next rising edge.
    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        rvfi   = '0;
        ready  = 1'b0;
        #1;
        chk("valid_in_reset", 64'(tv), 64'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rvfi_instr_t r0, r1, first;
        int          pops;
        bit          seen_done;

        rvfi  = '0;
        ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(tv), 64'd0);
        checks++;
        assert (tr === '0) else begin
            failures++;
            $error("FAIL rst_trace observed=%h expected=0", tr);
        end
        chk("rst_port", 64'(tp), 64'd0);
        chk("rst_overflow", 64'(ovf), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_exit", 64'(ec), 64'd0);
        rst_ni = 1'b1;

        // Two valid ports in one cycle, sink always ready.
        r0      = rand_rec(1, 0, 0);
        r1      = rand_rec(1, 0, 0);
        rvfi[0] = r0;
        rvfi[1] = r1;
        ready   = 1'b1;
        cycle();
        rvfi = '0;
        checks++;
        assert (tr === r0) else begin
            failures++;
            $error("FAIL t1_first observed=%h expected=%h", tr, r0);
        end
        chk("t1_port0", 64'(tp), 64'd0);
        cycle();
        checks++;
        assert (tr === r1) else begin
            failures++;
            $error("FAIL t1_second observed=%h expected=%h", tr, r1);
        end
        chk("t1_port1", 64'(tp), 64'd1);
        cycle();
        chk("t1_empty", 64'(tv), 64'd0);

        // Trap on port 0, valid on port 1, then non-qualifying noise.
        apply_reset();
        ready   = 1'b1;
        r0      = rand_rec(0, 1, 0);
        r1      = rand_rec(1, 0, 0);
        rvfi[0] = r0;
        rvfi[1] = r1;
        cycle();
        rvfi[0] = rand_rec(0, 0, 1);
        rvfi[1] = rand_rec(0, 0, 0);
        chk("t2_trap_port", 64'(tp), 64'd0);
        chk("t2_trap_bit", 64'(tr.trap), 64'd1);
        cycle();
        rvfi = '0;
        checks++;
        assert (tr === r1) else begin
            failures++;
            $error("FAIL t2_second observed=%h expected=%h", tr, r1);
        end
        cycle();
        chk("t2_noise_dropped", 64'(tv), 64'd0);
        cycle();

        // Overflow: sink stalled, two records per cycle for five cycles.
        apply_reset();
        ready = 1'b0;
        first = '0;
        for (int c = 0; c < 5; c++) begin
            rvfi[0] = rand_rec(1, 0, 0);
            rvfi[1] = rand_rec(1, 0, 0);
            if (c == 0) first = rvfi[0];
            if (c == 4) chk("t3_no_ovf_at_full", 64'(ovf), 64'd0);
            cycle();
        end
        rvfi = '0;
        chk("t3_overflow", 64'(ovf), 64'd1);
        checks++;
        assert (tr === first) else begin
            failures++;
            $error("FAIL t3_head_stable observed=%h expected=%h", tr, first);
        end
        ready = 1'b1;
        repeat (8) cycle();
        chk("t3_drained", 64'(tv), 64'd0);
        chk("t3_ovf_sticky", 64'(ovf), 64'd1);

        // Ecall on port 0 with port 1 valid and three entries already buffered.
        apply_reset();
        ready   = 1'b0;
        rvfi[0] = rand_rec(1, 0, 0);
        rvfi[1] = rand_rec(1, 0, 0);
        cycle();
        rvfi[0] = rand_rec(1, 0, 0);
        rvfi[1] = rand_rec(0, 0, 0);
        cycle();
        rvfi[0] = rand_rec(1, 0, 1);
        rvfi[1] = rand_rec(1, 0, 0);
        cycle();
        rvfi  = '0;
        chk("t4_exit_ecall", 64'(ec), 64'd1);
        chk("t4_no_ovf", 64'(ovf), 64'd0);
        ready     = 1'b1;
        pops      = 0;
        seen_done = 0;
        for (int c = 0; c < 10 && !seen_done; c++) begin
            if (tv && ready) pops++;
            cycle();
            if (done) seen_done = 1;
        end
        chk("t4_pops", 64'(pops), 64'd4);
        chk("t4_done", 64'(seen_done), 64'd1);

        // Timeout with random traffic and no ecall.
        apply_reset();
        for (int c = 0; c < 21; c++) begin
            rvfi[0] = rand_rec(1'($urandom), 1'($urandom_range(0, 7) == 0), 0);
            rvfi[1] = rand_rec(1'($urandom), 0, 0);
            ready   = 1'($urandom);
            cycle();
        end
        rvfi  = '0;
        ready = 1'b1;
        chk("t5_exit_timeout", 64'(ec), 64'd2);
        repeat (10) cycle();
        chk("t5_done", 64'(done), 64'd1);

        // Reset with five entries pending; counter must restart from zero.
        apply_reset();
        ready   = 1'b0;
        rvfi[0] = rand_rec(1, 0, 0);
        rvfi[1] = rand_rec(1, 0, 0);
        cycle();
        cycle();
        rvfi[1] = rand_rec(0, 0, 0);
        cycle();
        rvfi = '0;
        chk("t6_buffered", 64'(tv), 64'd1);
        apply_reset();
        for (int c = 0; c < 21; c++) cycle();
        chk("t6_exit_after_restart", 64'(ec), 64'd2);
        chk("t6_not_done_yet", 64'(done), 64'd0);
        cycle();
        chk("t6_done", 64'(done), 64'd1);

        // Random episodes, some with ecalls sprinkled in.
        for (int ep = 0; ep < 30; ep++) begin
            apply_reset();
            for (int c = 0; c < 40; c++) begin
                for (int i = 0; i < NR; i++) begin
                    rvfi[i] = rand_rec(1'($urandom_range(0, 3) != 0),
                                       1'($urandom_range(0, 7) == 0),
                                       1'((ep % 2 == 1) && ($urandom_range(0, 24) == 0)));
                end
                ready = 1'($urandom_range(0, 2) != 0);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_serializer.md
# rvfi_commit_serializer

Trace-side scheduler sitting between the core's multi-port RVFI commit interface and a single-record trace sink (tracer, DPI logger or checker). Each cycle it collects every commit port carrying a retired instruction or a trap, buffers them in program order, and releases them one at a time over a valid/ready handshake. It also owns end-of-simulation sequencing: it detects the terminating `ecall` or a cycle timeout, drains the buffer and then raises a done flag with an exit code.

## Interface
- `NR_COMMIT_PORTS`, 2, number of RVFI commit ports (1..4).
- `DEPTH`, 8, buffer entries; power of two, ≥ 2·NR_COMMIT_PORTS.
- `TIMEOUT_CYCLES`, 2000000, cycles after reset at which a timeout halt is forced.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `rvfi_i`  in  NR_COMMIT_PORTS × `rvfi_pkg::rvfi_instr_t`  commit records; index 0 is oldest.
- `trace_valid_o`  out  1  head record available.
- `trace_ready_i`  in  1  sink accepts head record.
- `trace_o`  out  `rvfi_pkg::rvfi_instr_t`  head record.
- `trace_port_o`  out  $clog2(NR_COMMIT_PORTS) (min 1)  commit port the head came from.
- `overflow_o`  out  1  sticky; a qualifying record was dropped.
- `sim_done_o`  out  1  halt sequence complete.
- `exit_code_o`  out  2  0 none, 1 ecall, 2 timeout.

## Operation
- Qualifying record: `rvfi_i[i].valid || rvfi_i[i].trap`. Others are ignored.
- Push: qualifying records are written in ascending port order, compacted (no holes). Free space = DEPTH − occupancy at start of cycle; a same-cycle pop does not create space for that cycle's pushes.
- If qualifying count exceeds free space: write the lowest-indexed records that fit, drop the rest, and set `overflow_o` (cleared only by reset).
- Pop: `trace_valid_o` = buffer non-empty; the head is removed when `trace_valid_o && trace_ready_i`. `trace_o`/`trace_port_o` are stable while valid and not ready.
- Halt FSM states: RUN, DRAIN, DONE.
  - RUN → DRAIN: a pushed record has `valid` and `insn == 32'h00000073` (exit_code 1), or the cycle counter reaches TIMEOUT_CYCLES (exit_code 2). Ecall wins if both happen in the same cycle. The ecall record itself and the lower-indexed records in its cycle are pushed; higher-indexed records in that cycle are discarded (no overflow).
  - DRAIN: no pushes; pops continue. → DONE when the buffer is empty.
  - DONE: terminal until reset; `sim_done_o` = 1, no pushes.
- Cycle counter: 32 bits, increments every cycle from reset, saturates at all-ones.
- `exit_code_o` is latched on entry to DRAIN and held.

## Timing
- Reset values: `trace_valid_o` 0, `trace_o` '0, `trace_port_o` 0, `overflow_o` 0, `sim_done_o` 0, `exit_code_o` 0; buffer empty, FSM RUN, counter 0.
- Latency: a record pushed at edge N is on `trace_o` with `trace_valid_o` = 1 after edge N (visible in cycle N+1) if the buffer was empty; throughput is one record per cycle.
- `sim_done_o` rises the cycle after the last pop in DRAIN; if DRAIN is entered with the buffer empty, it rises one cycle after entry.
- Reset asserted mid-operation empties the buffer immediately and discards all pending records.
- Read/write pointers are $clog2(DEPTH)+1 bits wide, so full and empty remain distinguishable across wrap-around.

## Structure
- `rvfi_pkg` gains `trace_halt_e` (RUN, DRAIN, DONE), `trace_exit_e` (NONE, ECALL, TIMEOUT) and the constant `ECALL_INSN = 32'h00000073`.
- Sub-module `rvfi_trace_fifo`: multi-push (up to NR_COMMIT_PORTS compacted writes per cycle), single-pop FIFO that reports occupancy and stores {record, port}. The top level holds the qualify/compaction logic, the FSM and the counter.

## Test plan
- Ports 0 and 1 both valid in one cycle, ready = 1 → port-0 record on `trace_o` in cycle N+1 and port-1 record in N+2, with `trace_port_o` = 0 then 1.
- Only port 1 valid, with a trap on port 0 → two records in order: trap first, then port 1; invalid non-trap ports produce nothing.
- Ready held at 0, two records per cycle for 5 cycles with DEPTH = 8 → occupancy 8 after 4 cycles; the 5th cycle's records are dropped and `overflow_o` = 1; head is stable and equal to the first record.
- Ecall on port 0 while port 1 is also valid, with 3 earlier entries buffered → port 1 discarded; 4 records drained; `sim_done_o` = 1 the cycle after the last pop; `exit_code_o` = 1.
- TIMEOUT_CYCLES = 20 with no ecall → DRAIN at cycle 20, then `exit_code_o` = 2 and `sim_done_o` = 1 once the buffer is empty.
- Reset pulsed with 5 entries buffered and ready = 0 → `trace_valid_o` 0 immediately; after release, the FSM is RUN and the counter restarts from 0.
